// File: rtl/menu_select_fsm.sv
// Menu navigation: debounced up/down/confirm pick one of NUM_BUTTONS entries; confirm latches a command and locks out input.
// Latency: raw press to idx/command update is DEBOUNCE_CYCLES+3 edges. Optional MENU_WRAP_EN wraps idx at the ends.
// No backpressure: command_valid_out is a one-cycle strobe; presses during lockout/wait-release are dropped.
module menu_select_fsm #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 371250,
  parameter int LOCKOUT_CYCLES  = 74250
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   menu_active_in,
  input  logic                   btn_up_in,
  input  logic                   btn_down_in,
  input  logic                   btn_confirm_in,
  output logic [1:0]             selected_idx_out,
  output logic [NUM_BUTTONS-1:0] selected_out,
  output logic [1:0]             command_out,
  output logic                   command_valid_out,
  output logic                   busy_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_BUTTONS - 1);
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_CONF = 2;

  typedef enum logic [1:0] {
    NAVIGATE,
    LOCKOUT,
    WAIT_RELEASE
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    press;
  logic [CW-1:0] db_cnt [3];

  assign raw = {btn_confirm_in, btn_down_in, btn_up_in};

  // Stable flips on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          vld_q, vld_d;
  logic [LW-1:0] lock_q, lock_d;

  logic [2:0] idx_ext;
  logic [2:0] idx_minus;
  logic [2:0] idx_plus;
  logic [1:0] idx_up;
  logic [1:0] idx_dn;

  // Step in 3 bits so underflow/overflow is visible before truncating back to 2.
  always_comb begin
    idx_ext   = {1'b0, idx_q};
    idx_minus = idx_ext - 3'd1;
    idx_plus  = idx_ext + 3'd1;
    idx_up    = idx_minus[1:0];
    idx_dn    = idx_plus[1:0];
    if (idx_minus[2]) begin
`ifdef MENU_WRAP_EN
      idx_up = IDX_LAST[1:0];
`else
      idx_up = idx_q;
`endif
    end
    if (idx_plus > IDX_LAST) begin
`ifdef MENU_WRAP_EN
      idx_dn = 2'd0;
`else
      idx_dn = idx_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    lock_d  = lock_q;
    if (!menu_active_in) begin
      state_d = NAVIGATE;
      idx_d   = 2'd0;
      lock_d  = '0;
    end else begin
      case (state_q)
        NAVIGATE: begin
          if (press[B_CONF]) begin
            cmd_d   = idx_q;
            vld_d   = 1'b1;
            lock_d  = LOCK_LOAD;
            state_d = LOCKOUT;
          end else if (press[B_UP] && !press[B_DOWN]) begin
            idx_d = idx_up;
          end else if (press[B_DOWN] && !press[B_UP]) begin
            idx_d = idx_dn;
          end
        end
        LOCKOUT: begin
          if (lock_q == '0) begin
            state_d = WAIT_RELEASE;
          end else begin
            lock_d = lock_q - LW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (!stable[B_CONF]) begin
            state_d = NAVIGATE;
          end
        end
        default: state_d = NAVIGATE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= NAVIGATE;
      idx_q   <= 2'd0;
      cmd_q   <= 2'd0;
      vld_q   <= 1'b0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    selected_out = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      selected_out[i] = menu_active_in && (idx_q == 2'(i));
    end
  end

  assign selected_idx_out  = idx_q;
  assign command_out       = cmd_q;
  assign command_valid_out = vld_q;
  assign busy_out          = (state_q == LOCKOUT) || (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_menu_select_fsm.sv
// Directed bench for menu_select_fsm with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, NUM_BUTTONS=4.
module tb_menu_select_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       active;
  logic       b_up;
  logic       b_down;
  logic       b_conf;
  logic [1:0] idx;
  logic [3:0] sel;
  logic [1:0] cmd;
  logic       vld;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  menu_select_fsm #(
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .menu_active_in   (active),
    .btn_up_in        (b_up),
    .btn_down_in      (b_down),
    .btn_confirm_in   (b_conf),
    .selected_idx_out (idx),
    .selected_out     (sel),
    .command_out      (cmd),
    .command_valid_out(vld),
    .busy_out         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up;
    logic       down;
    int         hold;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the raw buttons for 'hold' samples then lets them settle.
  task automatic pulse_btn(input logic u, input logic d, input logic c, input int hold);
    b_up   = u;
    b_down = d;
    b_conf = c;
    repeat (hold) @(negedge clk);
    b_up   = 1'b0;
    b_down = 1'b0;
    b_conf = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    logic [3:0] one_hot;
    logic [1:0] exp_tab [10];

`ifdef MENU_WRAP_EN
    exp_tab = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
`else
    exp_tab = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
`endif
    vecs[0] = '{1'b0, 1'b1, 10, exp_tab[0]};
    vecs[1] = '{1'b0, 1'b1, 3,  exp_tab[1]};
    vecs[2] = '{1'b0, 1'b1, 10, exp_tab[2]};
    vecs[3] = '{1'b0, 1'b1, 10, exp_tab[3]};
    vecs[4] = '{1'b0, 1'b1, 10, exp_tab[4]};
    vecs[5] = '{1'b1, 1'b0, 10, exp_tab[5]};
    vecs[6] = '{1'b1, 1'b0, 10, exp_tab[6]};
    vecs[7] = '{1'b1, 1'b0, 10, exp_tab[7]};
    vecs[8] = '{1'b1, 1'b0, 10, exp_tab[8]};
    vecs[9] = '{1'b1, 1'b1, 10, exp_tab[9]};

    rst    = 1'b1;
    active = 1'b1;
    b_up   = 1'b0;
    b_down = 1'b0;
    b_conf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_idx",  idx,  0);
    check("rst_sel",  sel,  4'b0001);
    check("rst_cmd",  cmd,  0);
    check("rst_vld",  vld,  0);
    check("rst_busy", busy, 0);

    // First-press latency: idx must move on edge 7, not earlier, and only once.
    b_down = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      @(negedge clk);
      check($sformatf("lat_idx_e%0d", e), idx, (e < 7) ? 0 : 1);
    end
    check("lat_sel", sel, 4'b0010);
    repeat (2) @(negedge clk);
    b_down = 1'b0;
    repeat (14) @(negedge clk);
    check("lat_once", idx, 1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pulse_btn(vecs[i].up, vecs[i].down, 1'b0, vecs[i].hold);
      one_hot = 4'b0001 << vecs[i].exp_idx;
      check($sformatf("vec%0d_idx", i), idx, vecs[i].exp_idx);
      check($sformatf("vec%0d_sel", i), sel, one_hot);
      check($sformatf("vec%0d_vld", i), vld, 0);
    end

    // Confirm at idx 2, held 30 samples, with a down press landing inside lockout.
    pulse_btn(1'b0, 1'b1, 1'b0, 10);
    pulse_btn(1'b0, 1'b1, 1'b0, 10);
    check("cf_pre_idx", idx, 2);
    b_conf = 1'b1;
    for (int e = 0; e <= 45; e++) begin
      @(negedge clk);
      check($sformatf("cf_vld_e%0d", e), vld, (e == 7) ? 1 : 0);
      check($sformatf("cf_busy_e%0d", e), busy, (e >= 7 && e <= 35) ? 1 : 0);
      check($sformatf("cf_idx_e%0d", e), idx, 2);
      if (e >= 7) check($sformatf("cf_cmd_e%0d", e), cmd, 2);
      if (e == 8)  b_down = 1'b1;
      if (e == 18) b_down = 1'b0;
      if (e == 29) b_conf = 1'b0;
    end

    // Confirm and down raw-asserted together at idx 1: confirm wins.
    pulse_btn(1'b1, 1'b0, 1'b0, 10);
    check("sim_pre_idx", idx, 1);
    b_conf = 1'b1;
    b_down = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(negedge clk);
      check($sformatf("sim_vld_e%0d", e), vld, (e == 7) ? 1 : 0);
      check($sformatf("sim_idx_e%0d", e), idx, 1);
      if (e == 7) check("sim_cmd", cmd, 1);
      if (e == 9) begin
        b_conf = 1'b0;
        b_down = 1'b0;
      end
    end
    check("sim_busy_end", busy, 0);

    // Menu inactive at idx 2.
    pulse_btn(1'b0, 1'b1, 1'b0, 10);
    check("ina_pre_idx", idx, 2);
    active = 1'b0;
    #1;
    check("ina_sel_comb", sel, 0);
    @(negedge clk);
    check("ina_idx", idx, 0);
    pulse_btn(1'b0, 1'b1, 1'b0, 10);
    check("ina_press_idx", idx, 0);
    check("ina_press_sel", sel, 0);
    check("ina_cmd_hold", cmd, 1);
    check("ina_vld", vld, 0);
    active = 1'b1;
    @(negedge clk);
    check("ina_back_sel", sel, 4'b0001);

    // Reset in the middle of a lockout.
    pulse_btn(1'b0, 1'b1, 1'b0, 10);
    b_conf = 1'b1;
    repeat (10) @(negedge clk);
    check("mrst_busy_pre", busy, 1);
    check("mrst_cmd_pre", cmd, 1);
    rst    = 1'b1;
    b_conf = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_cmd", cmd, 0);
    check("mrst_idx", idx, 0);
    check("mrst_vld", vld, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mrst_busy_late", busy, 0);
    check("mrst_vld_late", vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
